// File: rtl/v_ex_pkg.sv
// Shared vector-execute definitions: ALU opcodes (common to decode and execute),
// execute FSM state encoding and the default lane element width.
package v_ex_pkg;

    localparam int unsigned VEX_SEW   = 32;
    localparam int unsigned VALU_OP_W = 5;

    localparam logic [VALU_OP_W-1:0] VALU_OP_NOP  = 5'd0;
    localparam logic [VALU_OP_W-1:0] VALU_OP_VADD = 5'd1;
    localparam logic [VALU_OP_W-1:0] VALU_OP_VMUL = 5'd2;

    typedef enum logic [1:0] {
        VEX_IDLE = 2'd0,
        VEX_MUL  = 2'd1,
        VEX_OUT  = 2'd2
    } vex_state_e;

endpackage

// File: rtl/v_ex_lane_mul.sv
// Combinational SEW x SEW lane multiplier returning the low SEW bits of the product;
// the truncated product is identical for signed and unsigned operands.
module v_lane_mul
    import v_ex_pkg::*;
#(
    parameter int unsigned SEW = VEX_SEW
) (
    input  logic [SEW-1:0] a,
    input  logic [SEW-1:0] b,
    output logic [SEW-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/v_ex.sv
// Vector execute stage: single-cycle lane-wise VADD, iterative VMUL (MUL_LPC lanes per
// cycle), results handed to write-back over valid/ready with the write-back tags.
module v_ex
    import v_ex_pkg::*;
#(
    parameter int unsigned VLMAX     = 8,
    parameter int unsigned SEW       = VEX_SEW,
    parameter int unsigned VALUOP_DW = 5,
    parameter int unsigned VREG_DW   = 256,
    parameter int unsigned VREG_AW   = 5,
    parameter int unsigned MUL_LPC   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [VALUOP_DW-1:0] valu_opcode_i,
    input  logic [VREG_DW-1:0]   operand_v1_i,
    input  logic [VREG_DW-1:0]   operand_v2_i,
    input  logic                 wb_en_i,
    input  logic                 wb_sel_i,
    input  logic [VREG_AW-1:0]   wb_addr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [VREG_DW-1:0]   vex_result_o,
    output logic                 vex_wb_en_o,
    output logic                 vex_wb_sel_o,
    output logic [VREG_AW-1:0]   vex_wb_addr_o,
    output logic                 busy_o
);

    localparam int unsigned NGRP = VLMAX / MUL_LPC;
    localparam int unsigned CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

    vex_state_e state;
    logic [CW-1:0]      grp_cnt;
    logic [VREG_DW-1:0] op_a;
    logic [VREG_DW-1:0] op_b;
    logic [VREG_DW-1:0] result_q;
    logic               wb_en_q;
    logic               wb_sel_q;
    logic [VREG_AW-1:0] wb_addr_q;

    logic               accept;
    logic               is_vmul;
    logic [VREG_DW-1:0] alu_res;
    int unsigned        grp_base;

    logic [MUL_LPC-1:0][SEW-1:0] mul_a;
    logic [MUL_LPC-1:0][SEW-1:0] mul_b;
    logic [MUL_LPC-1:0][SEW-1:0] mul_p;

    assign out_valid_o = (state == VEX_OUT);
    assign busy_o      = (state == VEX_MUL);
    assign in_ready_o  = !rst && (state != VEX_MUL) && (!out_valid_o || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign is_vmul     = (valu_opcode_i == VALUOP_DW'(VALU_OP_VMUL));

    assign vex_result_o  = result_q;
    assign vex_wb_en_o   = wb_en_q;
    assign vex_wb_sel_o  = wb_sel_q;
    assign vex_wb_addr_o = wb_addr_q;

    // Single-cycle path; NOP and unknown opcodes yield zero.
    always_comb begin
        alu_res = '0;
        if (valu_opcode_i == VALUOP_DW'(VALU_OP_VADD)) begin
            for (int unsigned i = 0; i < VLMAX; i++) begin
                alu_res[i*SEW +: SEW] = operand_v1_i[i*SEW +: SEW] + operand_v2_i[i*SEW +: SEW];
            end
        end
    end

    always_comb begin
        grp_base = 32'(grp_cnt) * MUL_LPC;
        mul_a    = '0;
        mul_b    = '0;
        for (int unsigned k = 0; k < MUL_LPC; k++) begin
            mul_a[k] = op_a[(grp_base + k)*SEW +: SEW];
            mul_b[k] = op_b[(grp_base + k)*SEW +: SEW];
        end
    end

    for (genvar k = 0; k < MUL_LPC; k++) begin : g_mul
        v_lane_mul #(
            .SEW (SEW)
        ) u_lane_mul (
            .a (mul_a[k]),
            .b (mul_b[k]),
            .p (mul_p[k])
        );
    end

    // in_ready_o already excludes MUL and stalled OUT, so an accept always starts a
    // fresh op from IDLE or from a draining OUT (zero-bubble hand-over).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= VEX_IDLE;
            grp_cnt   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_sel_q  <= 1'b0;
            wb_addr_q <= '0;
        end else if (accept) begin
            wb_en_q   <= wb_en_i;
            wb_sel_q  <= wb_sel_i;
            wb_addr_q <= wb_addr_i;
            grp_cnt   <= '0;
            if (is_vmul) begin
                op_a  <= operand_v1_i;
                op_b  <= operand_v2_i;
                state <= VEX_MUL;
            end else begin
                result_q <= alu_res;
                state    <= VEX_OUT;
            end
        end else begin
            case (state)
                VEX_MUL: begin
                    for (int unsigned k = 0; k < MUL_LPC; k++) begin
                        result_q[(grp_base + k)*SEW +: SEW] <= mul_p[k];
                    end
                    if (grp_cnt == LAST_GRP) begin
                        grp_cnt <= '0;
                        state   <= VEX_OUT;
                    end else begin
                        grp_cnt <= grp_cnt + CW'(1);
                    end
                end
                VEX_OUT: begin
                    if (out_ready_i) begin
                        state <= VEX_IDLE;
                    end
                end
                default: state <= VEX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v_ex.sv
// Directed bench for v_ex: reset abort, VADD, VMUL latency/overflow, back-pressure and
// zero-bubble hand-over, vle NOP pass-through.
module tb_v_ex;
    import v_ex_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [4:0]   valu_opcode_i;
    logic [255:0] operand_v1_i;
    logic [255:0] operand_v2_i;
    logic         wb_en_i;
    logic         wb_sel_i;
    logic [4:0]   wb_addr_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [255:0] vex_result_o;
    logic         vex_wb_en_o;
    logic         vex_wb_sel_o;
    logic [4:0]   vex_wb_addr_o;
    logic         busy_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [255:0] exp_vec;
    logic [255:0] held_vec;

    v_ex #(
        .VLMAX     (8),
        .SEW       (32),
        .VALUOP_DW (5),
        .VREG_DW   (256),
        .VREG_AW   (5),
        .MUL_LPC   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .valu_opcode_i (valu_opcode_i),
        .operand_v1_i  (operand_v1_i),
        .operand_v2_i  (operand_v2_i),
        .wb_en_i       (wb_en_i),
        .wb_sel_i      (wb_sel_i),
        .wb_addr_i     (wb_addr_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .vex_result_o  (vex_result_o),
        .vex_wb_en_o   (vex_wb_en_o),
        .vex_wb_sel_o  (vex_wb_sel_o),
        .vex_wb_addr_o (vex_wb_addr_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_addr(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int unsigned max_cycles);
        int unsigned n = 0;
        while (!out_valid_o && n < max_cycles) begin
            step();
            n++;
        end
        check_bit(tag, out_valid_o, 1'b1);
    endtask

    function automatic logic [255:0] splat(input logic [31:0] x);
        return {8{x}};
    endfunction

    task automatic drive_op(input logic [4:0] op, input logic [255:0] v1, input logic [255:0] v2,
                            input logic en, input logic sel, input logic [4:0] addr);
        in_valid_i    = 1'b1;
        valu_opcode_i = op;
        operand_v1_i  = v1;
        operand_v2_i  = v2;
        wb_en_i       = en;
        wb_sel_i      = sel;
        wb_addr_i     = addr;
    endtask

    initial begin
        rst           = 1'b1;
        in_valid_i    = 1'b0;
        valu_opcode_i = 5'd0;
        operand_v1_i  = '0;
        operand_v2_i  = '0;
        wb_en_i       = 1'b0;
        wb_sel_i      = 1'b0;
        wb_addr_i     = 5'd0;
        out_ready_i   = 1'b1;
        #1;
        check_bit("rst_in_ready", in_ready_o, 1'b0);
        check_bit("rst_out_valid", out_valid_o, 1'b0);
        check_bit("rst_busy", busy_o, 1'b0);
        check_vec("rst_result", vex_result_o, '0);
        step();
        step();
        rst = 1'b0;
        #1;
        check_bit("post_rst_ready", in_ready_o, 1'b1);

        // Reset asserted mid-MUL aborts the op
        drive_op(VALU_OP_VMUL, splat(32'd3), splat(32'd5), 1'b1, 1'b0, 5'd4);
        step();
        in_valid_i = 1'b0;
        check_bit("mul_abort_busy", busy_o, 1'b1);
        step();
        rst = 1'b1;
        #1;
        check_bit("abort_busy", busy_o, 1'b0);
        check_bit("abort_ready", in_ready_o, 1'b0);
        check_bit("abort_valid", out_valid_o, 1'b0);
        check_addr("abort_addr", vex_wb_addr_o, 5'd0);
        step();
        rst = 1'b0;
        step();
        check_bit("abort_ready_after", in_ready_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_bit("abort_no_token", out_valid_o, 1'b0);
            step();
        end

        // VADD with per-lane wrap
        drive_op(VALU_OP_VADD, splat(32'hFFFF_FFFF), splat(32'd2), 1'b1, 1'b0, 5'd5);
        step();
        in_valid_i = 1'b0;
        check_bit("vadd_valid", out_valid_o, 1'b1);
        check_vec("vadd_result", vex_result_o, splat(32'h0000_0001));
        check_bit("vadd_wb_en", vex_wb_en_o, 1'b1);
        check_bit("vadd_wb_sel", vex_wb_sel_o, 1'b0);
        check_addr("vadd_wb_addr", vex_wb_addr_o, 5'd5);
        step();
        check_bit("vadd_drained", out_valid_o, 1'b0);

        // VMUL latency, busy window and operand latching
        for (int i = 0; i < 8; i++) begin
            operand_v1_i[i*32 +: 32] = 32'(i + 1);
            exp_vec[i*32 +: 32]      = 32'(i + 1) << 16;
        end
        drive_op(VALU_OP_VMUL, operand_v1_i, splat(32'h0001_0000), 1'b1, 1'b0, 5'd6);
        step();
        in_valid_i   = 1'b0;
        operand_v1_i = splat(32'hDEAD_BEEF);
        operand_v2_i = splat(32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            check_bit("vmul_busy", busy_o, 1'b1);
            check_bit("vmul_ready_low", in_ready_o, 1'b0);
            check_bit("vmul_not_valid", out_valid_o, 1'b0);
            step();
        end
        check_bit("vmul_valid_at_5", out_valid_o, 1'b1);
        check_bit("vmul_busy_done", busy_o, 1'b0);
        check_vec("vmul_result", vex_result_o, exp_vec);
        check_addr("vmul_wb_addr", vex_wb_addr_o, 5'd6);
        step();
        check_bit("vmul_drained", out_valid_o, 1'b0);

        // VMUL overflow truncation
        operand_v1_i = {{4{32'hFFFF_FFFF}}, {4{32'h8000_0000}}};
        operand_v2_i = {{4{32'hFFFF_FFFF}}, {4{32'h0000_0003}}};
        drive_op(VALU_OP_VMUL, operand_v1_i, operand_v2_i, 1'b1, 1'b0, 5'd1);
        step();
        in_valid_i = 1'b0;
        wait_valid("vmul_ovf_timeout", 10);
        check_vec("vmul_ovf_result", vex_result_o, {{4{32'h0000_0001}}, {4{32'h8000_0000}}});
        step();

        // Back-pressure, then zero-bubble hand-over
        out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            operand_v1_i[i*32 +: 32] = 32'h1000_0000 + 32'(i);
            operand_v2_i[i*32 +: 32] = 32'(i);
            held_vec[i*32 +: 32]     = 32'h1000_0000 + 32'(2 * i);
        end
        drive_op(VALU_OP_VADD, operand_v1_i, operand_v2_i, 1'b1, 1'b0, 5'd3);
        step();
        drive_op(VALU_OP_VADD, splat(32'h1111_1111), splat(32'h2222_2222), 1'b1, 1'b1, 5'd9);
        check_bit("bp_valid", out_valid_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_bit("bp_hold_valid", out_valid_o, 1'b1);
            check_vec("bp_hold_result", vex_result_o, held_vec);
            check_addr("bp_hold_addr", vex_wb_addr_o, 5'd3);
            check_bit("bp_ready_low", in_ready_o, 1'b0);
        end
        out_ready_i = 1'b1;
        #1;
        check_bit("bp_ready_release", in_ready_o, 1'b1);
        step();
        in_valid_i = 1'b0;
        check_bit("handover_valid", out_valid_o, 1'b1);
        check_vec("handover_result", vex_result_o, splat(32'h3333_3333));
        check_addr("handover_addr", vex_wb_addr_o, 5'd9);
        check_bit("handover_sel", vex_wb_sel_o, 1'b1);
        step();
        check_bit("handover_drained", out_valid_o, 1'b0);

        // vle NOP pass-through and back-to-back tokens (incl. an unknown opcode)
        drive_op(VALU_OP_NOP, splat(32'h5555_5555), splat(32'h0000_0001), 1'b1, 1'b1, 5'd7);
        step();
        check_bit("nop_valid", out_valid_o, 1'b1);
        check_vec("nop_result", vex_result_o, '0);
        check_bit("nop_wb_en", vex_wb_en_o, 1'b1);
        check_bit("nop_wb_sel", vex_wb_sel_o, 1'b1);
        check_addr("nop_wb_addr", vex_wb_addr_o, 5'd7);
        wb_addr_i = 5'd8;
        step();
        check_bit("b2b_valid_1", out_valid_o, 1'b1);
        check_addr("b2b_addr_1", vex_wb_addr_o, 5'd8);
        valu_opcode_i = 5'd5;
        wb_addr_i     = 5'd10;
        step();
        in_valid_i = 1'b0;
        check_bit("b2b_valid_2", out_valid_o, 1'b1);
        check_addr("b2b_addr_2", vex_wb_addr_o, 5'd10);
        check_vec("unknown_op_result", vex_result_o, '0);
        step();
        check_bit("b2b_drained", out_valid_o, 1'b0);
        check_bit("final_ready", in_ready_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
